keypad_scanner: RTL and testbench
=================================

Name: keypad_scanner

Overview:
Parametrised matrix-keypad scanner, the successor to the combinational switch-and-row key decoder. It drives the columns itself and samples synchronised row inputs, replacing the manual switch-driven column selection. Each press is debounced and reported as a one-cycle key event with a binary key code. A seven-segment (HEX) display latches the last valid key. Sits between the board GPIO keypad header and downstream logic or HEX0.

Parameters:
ROWS, 4, number of keypad rows (2..8)
COLS, 4, number of keypad columns (2..8)
SCAN_DIV, 5000, clock cycles per column slot; must be >= 4 so row sync and settling complete inside a slot
DEBOUNCE_SCANS, 4, consecutive matching slot samples required to accept a press or a release (>= 1)
CODE_W, $clog2(ROWS*COLS), key code width (derived, not overridden)

Ports:
CLOCK_50  in   1        system clock
reset     in   1        asynchronous, active-high reset
row_n     in   ROWS     keypad rows, active-low (pulled up), asynchronous
col_n     out  COLS     column drive, active-low, exactly one bit low at all times
key_valid out  1        one-cycle pulse when a debounced press is accepted
key_code  out  CODE_W   row_index*COLS + col_index of the last accepted key
key_held  out  1        high while the accepted key remains pressed
multi_err out  1        one-cycle pulse when more than one row is low in the active column
HEX0      out  7        active-low segments {g,f,e,d,c,b,a} showing key_code as a hex digit (low 4 bits)

Behaviour:
- Reset (async, any state) clears all of the following immediately: state=SCAN, col index=0 (col_n = all ones except bit 0), slot counter=0, debounce count=0, sync flops=all ones, key_valid=0, multi_err=0, key_held=0, key_code=0, HEX0=7'b1111111 (blank).
- row_n passes through a 2-flop synchroniser. All decisions use the synchronised value sampled on the last cycle of a slot (slot counter == SCAN_DIV-1). This is the "slot sample."
- Slot counter runs continuously 0..SCAN_DIV-1 and wraps. The column index advances (wrapping COLS-1 -> 0) only at slot end while in SCAN, or on exit from DEBOUNCE by mismatch, or on exit from RELEASE.
- SCAN: at slot sample, if rows are all high, advance the column. If exactly one row is low, capture row/col as the candidate, set count=1, hold the column, and go to DEBOUNCE (or accept immediately if DEBOUNCE_SCANS==1). If two or more rows are low, pulse multi_err and advance the column.
- DEBOUNCE: column held. At each slot sample, if the pattern equals the candidate, increment count. When count reaches DEBOUNCE_SCANS, the press is accepted:
  - key_valid pulses for exactly 1 cycle (the cycle after the sample);
  - key_code and HEX0 update in that same cycle;
  - key_held=1; go to HELD.
  Any other pattern returns to SCAN with count=0, advances the column, and emits no event.
- HELD: column held. When a slot sample shows all rows high, set count=1 and go to RELEASE. Any low pattern stays in HELD; a changed pattern does not generate a new event.
- RELEASE: at slot sample, all rows high increments count; at DEBOUNCE_SCANS, key_held=0, advance the column, and go to SCAN. Any row low returns to HELD with count=0 and no new key_valid.
- key_code and HEX0 hold their value until the next accepted press; they are not cleared on release.
- HEX encoding: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
- Press-to-key_valid latency: at most (COLS + DEBOUNCE_SCANS)*SCAN_DIV + 3 cycles.

Decomposition:
- Shared package keypad_pkg:
  - state enum {SCAN, DEBOUNCE, HELD, RELEASE};
  - 16-entry seg7 hex constant table;
  - BLANK_SEG = 7'b1111111.
- Sub-module hex_to_seg7: combinational 4-bit -> 7-segment lookup using the package table. It replaces the hand-minimised sum-of-products decoder.

Test Plan:
- Reset mid-DEBOUNCE (SCAN_DIV=4, DEBOUNCE_SCANS=3) -> outputs go to reset values in the same cycle, col_n=4'b1110, HEX0=1111111.
- Idle (no key) -> col_n cycles 1110, 1101, 1011, 0111, 1110, each held 4 cycles; no key_valid or multi_err.
- Hold row 2 low while col 1 is active, stable -> exactly one key_valid; key_code=9; HEX0=0010000; key_held=1 until 3 all-high samples after release.
- Press row 0 at col 0 with a 1-slot glitch (row high at the 2nd sample) -> no key_valid, scanning resumes at col 1.
- Rows 1 and 3 low at col 2 -> multi_err pulses once per visit to col 2; key_code unchanged.
- Bounce on release (high, low, high, high, high) -> key_held stays 1 through the bounce; no second key_valid; key_held falls after the final 3 highs.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and constants for the matrix keypad scanner.
// Latency: n/a (types and constants only).
// Backpressure: n/a; no ports.
package keypad_pkg;

    // Scanner phases: hunting for a key, confirming a press, key down,
    // confirming a release.
    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    // All segments off (active-low display).
    localparam logic [6:0] BLANK_SEG = 7'b1111111;

    // Active-low {g,f,e,d,c,b,a} patterns for hex digits 0..F.
    localparam logic [6:0] SEG7_TABLE [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

endpackage

// File: rtl/hex_to_seg7.sv
// Hex digit to active-low seven-segment pattern lookup.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of the input.
// Ports: hex_i - 4-bit digit; seg_o - segments {g,f,e,d,c,b,a}, active-low.
module hex_to_seg7
    import keypad_pkg::*;
(
    input  logic [3:0] hex_i,
    output logic [6:0] seg_o
);

    assign seg_o = SEG7_TABLE[hex_i];

endmodule

// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: drives one column low per slot, debounces presses
// and releases, reports a one-cycle key event plus a latched HEX digit.
// Latency: press-to-key_valid <= (COLS + DEBOUNCE_SCANS)*SCAN_DIV + 3 cycles.
// Backpressure: none; key_valid/multi_err are fire-and-forget pulses.
// Ports: CLOCK_50/reset (async, active-high); row_n async active-low rows;
//        col_n one-cold column drive; key_valid, key_code, key_held,
//        multi_err status; HEX0 active-low digit of key_code[3:0].
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter  int ROWS           = 4,
    parameter  int COLS           = 4,
    parameter  int SCAN_DIV       = 5000,
    parameter  int DEBOUNCE_SCANS = 4,
    localparam int CODE_W         = $clog2(ROWS*COLS)
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic [ROWS-1:0]   row_n,
    output logic [COLS-1:0]   col_n,
    output logic              key_valid,
    output logic [CODE_W-1:0] key_code,
    output logic              key_held,
    output logic              multi_err,
    output logic [6:0]        HEX0
);

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam int COL_W = $clog2(COLS);
    localparam int ROW_W = $clog2(ROWS);
    localparam int DBC_W = $clog2(DEBOUNCE_SCANS + 1);

    localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(COLS - 1);
    localparam logic [DBC_W-1:0] DBC_DONE  = DBC_W'(DEBOUNCE_SCANS);

    logic [ROWS-1:0]   sync1_q, sync2_q;
    logic [CNT_W-1:0]  slot_q;
    logic [COL_W-1:0]  col_q, col_d;
    state_t            state_q, state_d;
    logic [DBC_W-1:0]  dbc_q, dbc_d;
    logic [ROW_W-1:0]  cand_q, cand_d;
    logic              key_valid_q, key_valid_d;
    logic              multi_err_q, multi_err_d;
    logic              key_held_q, key_held_d;
    logic [CODE_W-1:0] key_code_q, key_code_d;
    logic [6:0]        hex_q, hex_d;

    logic              slot_end;
    logic              all_high, one_low;
    logic [3:0]        low_cnt;
    logic [ROW_W-1:0]  low_idx;
    logic [COL_W-1:0]  col_next;
    logic [DBC_W-1:0]  dbc_inc;
    logic              accept;
    logic [3:0]        code_nib;
    logic [6:0]        seg_next;

    assign slot_end = (slot_q == SLOT_LAST);
    assign col_next = (col_q == COL_LAST) ? '0 : col_q + COL_W'(1);
    assign dbc_inc  = dbc_q + DBC_W'(1);

    // Count low rows on the synchronised sample; low_idx is only meaningful
    // when exactly one row is low.
    always_comb begin
        low_cnt = '0;
        low_idx = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (!sync2_q[r]) begin
                low_cnt = low_cnt + 4'd1;
                low_idx = ROW_W'(r);
            end
        end
    end

    assign all_high = (low_cnt == 4'd0);
    assign one_low  = (low_cnt == 4'd1);

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        dbc_d       = dbc_q;
        cand_d      = cand_q;
        key_valid_d = 1'b0;
        multi_err_d = 1'b0;
        key_held_d  = key_held_q;
        key_code_d  = key_code_q;
        accept      = 1'b0;
        if (slot_end) begin
            case (state_q)
                SCAN: begin
                    if (all_high) begin
                        col_d = col_next;
                    end else if (one_low) begin
                        cand_d = low_idx;
                        if (DEBOUNCE_SCANS == 1) begin
                            accept = 1'b1;
                        end else begin
                            dbc_d   = DBC_W'(1);
                            state_d = DEBOUNCE;
                        end
                    end else begin
                        multi_err_d = 1'b1;
                        col_d       = col_next;
                    end
                end
                DEBOUNCE: begin
                    if (one_low && (low_idx == cand_q)) begin
                        if (dbc_inc == DBC_DONE) accept = 1'b1;
                        else                     dbc_d  = dbc_inc;
                    end else begin
                        state_d = SCAN;
                        dbc_d   = '0;
                        col_d   = col_next;
                    end
                end
                HELD: begin
                    // First all-high sample already counts toward release.
                    if (all_high) begin
                        if (DEBOUNCE_SCANS == 1) begin
                            state_d    = SCAN;
                            key_held_d = 1'b0;
                            dbc_d      = '0;
                            col_d      = col_next;
                        end else begin
                            dbc_d   = DBC_W'(1);
                            state_d = RELEASE;
                        end
                    end
                end
                RELEASE: begin
                    if (all_high) begin
                        if (dbc_inc == DBC_DONE) begin
                            state_d    = SCAN;
                            key_held_d = 1'b0;
                            dbc_d      = '0;
                            col_d      = col_next;
                        end else begin
                            dbc_d = dbc_inc;
                        end
                    end else begin
                        state_d = HELD;
                        dbc_d   = '0;
                    end
                end
                default: begin
                    state_d = SCAN;
                    dbc_d   = '0;
                end
            endcase
            if (accept) begin
                state_d     = HELD;
                dbc_d       = '0;
                key_valid_d = 1'b1;
                key_held_d  = 1'b1;
                key_code_d  = CODE_W'(cand_d) * CODE_W'(COLS) + CODE_W'(col_q);
            end
        end
    end

    // Display shows the low hex digit of the code, zero-extended if narrow.
    if (CODE_W >= 4) begin : g_nib_trunc
        assign code_nib = key_code_d[3:0];
    end else begin : g_nib_ext
        assign code_nib = {{(4-CODE_W){1'b0}}, key_code_d};
    end

    hex_to_seg7 u_seg (
        .hex_i (code_nib),
        .seg_o (seg_next)
    );

    // HEX0 is registered so it can show blank after reset while key_code is 0.
    assign hex_d = accept ? seg_next : hex_q;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            sync1_q     <= '1;
            sync2_q     <= '1;
            slot_q      <= '0;
            col_q       <= '0;
            state_q     <= SCAN;
            dbc_q       <= '0;
            cand_q      <= '0;
            key_valid_q <= 1'b0;
            multi_err_q <= 1'b0;
            key_held_q  <= 1'b0;
            key_code_q  <= '0;
            hex_q       <= BLANK_SEG;
        end else begin
            sync1_q     <= row_n;
            sync2_q     <= sync1_q;
            slot_q      <= slot_end ? '0 : slot_q + CNT_W'(1);
            col_q       <= col_d;
            state_q     <= state_d;
            dbc_q       <= dbc_d;
            cand_q      <= cand_d;
            key_valid_q <= key_valid_d;
            multi_err_q <= multi_err_d;
            key_held_q  <= key_held_d;
            key_code_q  <= key_code_d;
            hex_q       <= hex_d;
        end
    end

    assign col_n     = ~(COLS'(1) << col_q);
    assign key_valid = key_valid_q;
    assign key_code  = key_code_q;
    assign key_held  = key_held_q;
    assign multi_err = multi_err_q;
    assign HEX0      = hex_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Testbench for keypad_scanner: keypad matrix model plus slot-level reference.
// Latency: n/a.
// Backpressure: n/a.
module tb_keypad_scanner;

    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int SDIV = 4;
    localparam int DEB  = 3;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [ROWS-1:0] row_n;
    logic [COLS-1:0] col_n;
    logic            key_valid, key_held, multi_err;
    logic [3:0]      key_code;
    logic [6:0]      hex0;

    // keys[r][c] = 1 when the switch at row r / column c is closed.
    logic [COLS-1:0] keys [ROWS];

    keypad_scanner #(
        .ROWS           (ROWS),
        .COLS           (COLS),
        .SCAN_DIV       (SDIV),
        .DEBOUNCE_SCANS (DEB)
    ) dut (
        .CLOCK_50  (clk),
        .reset     (rst),
        .row_n     (row_n),
        .col_n     (col_n),
        .key_valid (key_valid),
        .key_code  (key_code),
        .key_held  (key_held),
        .multi_err (multi_err),
        .HEX0      (hex0)
    );

    always #5 clk = ~clk;

    // A closed switch pulls its row low while its column is driven low.
    always_comb begin
        for (int r = 0; r < ROWS; r++) row_n[r] = ~|(keys[r] & ~col_n);
    end

    logic [6:0] seg_ref [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };
    logic [3:0] idle_pat [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    int n_cmp = 0;
    int n_bad = 0;
    int dut_valid_cnt = 0;
    int dut_merr_cnt  = 0;

    // Reference: the scanner either roams (unlocked) or sits on one column.
    // While sitting, it first counts identical single-key samples, then once
    // pressed counts consecutive all-open samples until released.
    int         m_col, m_row, m_streak;
    bit         m_locked, m_pressed;
    logic       exp_valid, exp_merr, exp_held;
    int         exp_code;
    logic [6:0] exp_hex;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_col = 0; m_row = 0; m_streak = 0;
        m_locked = 0; m_pressed = 0;
        exp_valid = 0; exp_merr = 0; exp_held = 0;
        exp_code = 0; exp_hex = 7'b1111111;
    endtask

    task automatic model_step();
        int n, idx;
        n = 0; idx = 0;
        for (int r = 0; r < ROWS; r++) begin
            if (keys[r][m_col]) begin n++; idx = r; end
        end
        exp_valid = 0;
        exp_merr  = 0;
        if (!m_locked) begin
            if (n == 1) begin
                m_locked = 1; m_row = idx; m_streak = 1;
            end else begin
                if (n > 1) exp_merr = 1;
                m_col = (m_col + 1) % COLS;
            end
        end else if (!m_pressed) begin
            if (n == 1 && idx == m_row) m_streak++;
            else begin
                m_locked = 0; m_streak = 0; m_col = (m_col + 1) % COLS;
            end
        end else begin
            if (n == 0) m_streak++;
            else        m_streak = 0;
            if (m_streak == DEB) begin
                m_pressed = 0; m_locked = 0; m_streak = 0;
                exp_held = 0; m_col = (m_col + 1) % COLS;
            end
        end
        if (m_locked && !m_pressed && m_streak == DEB) begin
            m_pressed = 1; m_streak = 0;
            exp_valid = 1; exp_held = 1;
            exp_code  = m_row * COLS + m_col;
            exp_hex   = seg_ref[exp_code % 16];
        end
    endtask

    task automatic check_outputs();
        logic [COLS-1:0] ec;
        ec = ~(COLS'(1) << m_col);
        chk("col_n", col_n, ec);
        chk("key_valid", key_valid, exp_valid);
        chk("multi_err", multi_err, exp_merr);
        chk("key_held", key_held, exp_held);
        chk("key_code", key_code, exp_code);
        chk("HEX0", hex0, exp_hex);
        if (key_valid === 1'b1) dut_valid_cnt++;
        if (multi_err === 1'b1) dut_merr_cnt++;
    endtask

    // Entered at the negedge of the first cycle of a slot; leaves at the
    // same point of the next slot.
    task automatic run_slot();
        logic [COLS-1:0] ec;
        check_outputs();
        ec = ~(COLS'(1) << m_col);
        model_step();
        for (int i = 1; i < SDIV; i++) begin
            @(posedge clk); @(negedge clk);
            chk("col_mid", col_n, ec);
            chk("valid_mid", key_valid, 1'b0);
            chk("merr_mid", multi_err, 1'b0);
        end
        @(posedge clk); @(negedge clk);
    endtask

    task automatic clear_keys();
        for (int r = 0; r < ROWS; r++) keys[r] = '0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_keys();
        model_reset();
        #2 rst = 1'b1;
        #1;
        chk("rst_col", col_n, 4'b1110);
        chk("rst_hex", hex0, 7'b1111111);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        // Idle scanning
        for (int s = 0; s < 8; s++) begin
            chk("idle_col", col_n, idle_pat[s % 4]);
            run_slot();
        end

        // Stable press at row 2 / col 1, then clean release
        dut_valid_cnt = 0;
        keys[2][1] = 1'b1;
        for (int s = 0; s < 10; s++) run_slot();
        chk("k9_events", dut_valid_cnt, 1);
        chk("k9_code", key_code, 4'd9);
        chk("k9_hex", hex0, 7'b0010000);
        chk("k9_held", key_held, 1'b1);
        keys[2][1] = 1'b0;
        run_slot(); run_slot();
        chk("k9_held_2hi", key_held, 1'b1);
        run_slot();
        chk("k9_released", key_held, 1'b0);

        // One-slot glitch at row 0 / col 0
        for (int s = 0; s < 8 && !(m_col == 0 && !m_locked); s++) run_slot();
        chk("glitch_at_col0", col_n, 4'b1110);
        dut_valid_cnt = 0;
        keys[0][0] = 1'b1;
        run_slot();
        keys[0][0] = 1'b0;
        run_slot();
        chk("glitch_resume", col_n, 4'b1101);
        for (int s = 0; s < 4; s++) run_slot();
        chk("glitch_events", dut_valid_cnt, 0);

        // Rows 1 and 3 on column 2
        dut_merr_cnt = 0;
        keys[1][2] = 1'b1; keys[3][2] = 1'b1;
        for (int s = 0; s < 8; s++) run_slot();
        clear_keys();
        run_slot();
        chk("multi_count", dut_merr_cnt, 2);
        chk("multi_code", key_code, 4'd9);

        // Release bounce on row 1 / col 3
        dut_valid_cnt = 0;
        keys[1][3] = 1'b1;
        for (int s = 0; s < 12 && !m_pressed; s++) run_slot();
        run_slot();
        chk("bounce_press", key_held, 1'b1);
        chk("bounce_code", key_code, 4'd7);
        begin
            logic bpat [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
            logic bheld [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
            for (int s = 0; s < 5; s++) begin
                keys[1][3] = bpat[s];
                run_slot();
                chk("bounce_held", key_held, bheld[s]);
            end
        end
        chk("bounce_events", dut_valid_cnt, 1);

        // Randomised key activity
        for (int s = 0; s < 300; s++) begin
            if ($urandom_range(0, 3) == 0) begin
                int sel;
                sel = $urandom_range(0, 9);
                if (sel < 7) clear_keys();
                if (sel >= 3) keys[$urandom_range(0, ROWS-1)][$urandom_range(0, COLS-1)] = 1'b1;
                if (sel >= 7) keys[$urandom_range(0, ROWS-1)][$urandom_range(0, COLS-1)] = 1'b1;
            end
            run_slot();
        end

        // Reset in the middle of a press confirmation
        clear_keys();
        for (int s = 0; s < 10 && m_locked; s++) run_slot();
        chk("pre_idle", key_held, 1'b0);
        keys[3][1] = 1'b1;
        for (int s = 0; s < 12 && !m_pressed; s++) run_slot();
        run_slot();
        chk("pre_press", key_held, 1'b1);
        clear_keys();
        for (int s = 0; s < 10 && m_locked; s++) run_slot();
        chk("pre_release", key_held, 1'b0);
        keys[2][0] = 1'b1;
        for (int s = 0; s < 12 && !(m_locked && m_streak >= 2); s++) run_slot();
        chk("pre_code", key_code, 4'd13);
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_col", col_n, 4'b1110);
        chk("mid_rst_hex", hex0, 7'b1111111);
        chk("mid_rst_code", key_code, 4'd0);
        chk("mid_rst_held", key_held, 1'b0);
        chk("mid_rst_valid", key_valid, 1'b0);
        chk("mid_rst_merr", multi_err, 1'b0);
        clear_keys();
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int s = 0; s < 6; s++) run_slot();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
